// File: rtl/cla_seq_addsub_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder/subtractor.
package cla_seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB = 4;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_seq_addsub_cla4.sv
// Existing 4-bit carry-lookahead slice: all four carries are flattened sums of products.
module cla4
  import cla_seq_addsub_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           ci,
  output logic [NIB-1:0] s,
  output logic           co
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[NIB-1:0];
    co   = c[NIB];
  end

endmodule

// File: rtl/cla_seq_addsub.sv
// Sequences one shared cla4 slice over a WORDS-nibble operand, LSB nibble first,
// with a registered ripple carry between steps; subtraction via ~b plus carry-in 1.
module cla_seq_addsub
  import cla_seq_addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [NIB*WORDS-1:0] a,
  input  logic [NIB*WORDS-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [NIB*WORDS-1:0] s,
  output logic                 co,
  output logic                 ovf
);

  localparam int N     = NIB * WORDS;
  localparam int IDX_W = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             load;

  logic [NIB-1:0]   nib_a;
  logic [NIB-1:0]   nib_b;
  logic [NIB-1:0]   nib_s;
  logic             nib_co;

  assign nib_a = a_q[int'(idx_q)*NIB +: NIB];
  assign nib_b = b_q[int'(idx_q)*NIB +: NIB];

  cla4 u_cla4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        load = start;
      end
      RUN: begin
        busy                      = 1'b1;
        s_d[int'(idx_q)*NIB +: NIB] = nib_s;
        carry_d                   = nib_co;
        idx_d                     = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          co_d    = nib_co;
          // Overflow judged on the latched operands and the final sum MSB.
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (nib_s[NIB-1] != a_q[N-1]);
        end
      end
      DONE: begin
        done    = 1'b1;
        load    = start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = RUN;
      a_d     = a;
      b_d     = op_sub ? ~b : b;
      carry_d = op_sub;
      idx_d   = '0;
      s_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand latches carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign s   = s_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Bench for cla_seq_addsub: a WORDS=4 and a WORDS=1 instance against an integer reference model.
module tb_cla_seq_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, op_sub4, busy4, done4, co4, ovf4;
  logic [15:0] a4, b4, s4;
  logic        start1, op_sub1, busy1, done1, co1, ovf1;
  logic [3:0]  a1, b1, s1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cla_seq_addsub #(.WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_sub(op_sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  cla_seq_addsub #(.WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, co, s} from signed/unsigned integer arithmetic on a w-bit word.
  function automatic logic [17:0] model(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                        input bit sub);
    int   mask, half, ua, ub, sa, sb, r, res;
    logic c, v;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(ra) & mask;
    ub   = int'(rb) & mask;
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    r    = sub ? sa - sb : sa + sb;
    v    = (r >= half) || (r < -half);
    res  = sub ? ua - ub : ua + ub;
    c    = sub ? (ua >= ub) : (res > mask);
    return {v, c, 16'(res & mask)};
  endfunction

  task automatic drive(input bit one, input bit st, input logic [15:0] ra, input logic [15:0] rb,
                       input bit sub);
    if (one) begin
      start1 = st; a1 = ra[3:0]; b1 = rb[3:0]; op_sub1 = sub;
    end else begin
      start4 = st; a4 = ra; b4 = rb; op_sub4 = sub;
    end
  endtask

  // One operation; optionally pulses start with other operands at RUN cycle pulse_at.
  task automatic run_op(input bit one, input logic [15:0] ra, input logic [15:0] rb, input bit sub,
                        input int pulse_at, input string tag);
    logic [17:0] e;
    int          cyc, nbusy, both;
    logic        bz, dn;
    e = model(one ? 1 * 4 : 16, ra, rb, sub);
    @(negedge clk);
    drive(one, 1'b1, ra, rb, sub);
    @(negedge clk);
    drive(one, 1'b0, 16'($urandom), 16'($urandom), ~sub);
    cyc = 1; nbusy = 0; both = 0;
    forever begin
      bz = one ? busy1 : busy4;
      dn = one ? done1 : done4;
      if (bz) nbusy++;
      if (bz && dn) both++;
      if (dn || cyc >= 20) break;
      @(negedge clk);
      cyc++;
      drive(one, (cyc == pulse_at), 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1);
    end
    drive(one, 1'b0, 16'($urandom), 16'($urandom), sub);
    chk({tag, "_latency"}, cyc, one ? 2 : 5);
    chk({tag, "_busy_cycles"}, nbusy, one ? 1 : 4);
    chk({tag, "_busy_and_done"}, both, 0);
    chk({tag, "_s"}, one ? {28'd0, s1} : {16'd0, s4}, one ? {28'd0, e[3:0]} : {16'd0, e[15:0]});
    chk({tag, "_co"}, one ? co1 : co4, e[16]);
    chk({tag, "_ovf"}, one ? ovf1 : ovf4, e[17]);
    @(negedge clk);
    chk({tag, "_idle_after"}, one ? {busy1, done1} : {busy4, done4}, 2'b00);
  endtask

  initial begin
    logic [17:0] e1, e2;
    logic [15:0] x1, y1, x2, y2;
    int          t1, t2, cyc, ndone;

    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_state4", {busy4, done4, co4, ovf4, s4}, 20'h0);
    chk("reset_state1", {busy1, done1, co1, ovf1, s1}, 8'h0);
    reset = 1'b0;

    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 0, "add_1_1");
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, "add_ffff_1");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, "add_7fff_1");
    run_op(1'b0, 16'h0005, 16'h0007, 1'b1, 0, "sub_5_7");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 0, "sub_8000_1");
    run_op(1'b0, 16'h1234, 16'h1234, 1'b1, 0, "sub_equal");
    for (int i = 0; i < 8; i++)
      run_op(1'b0, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 0, "rand4");

    // start pulsed in the 2nd RUN cycle must be ignored
    run_op(1'b0, 16'h00FF, 16'h0F01, 1'b0, 2, "start_in_run");

    // start held high through DONE: back-to-back acceptance
    x1 = 16'($urandom); y1 = 16'($urandom); x2 = 16'($urandom); y2 = 16'($urandom);
    e1 = model(16, x1, y1, 1'b0);
    e2 = model(16, x2, y2, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, x1, y1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, x2, y2, 1'b1);
    cyc = 1; t1 = 0; t2 = 0;
    while (cyc < 30 && t2 == 0) begin
      if (done4 && t1 == 0) begin
        t1 = cyc;
        chk("b2b_first_s", s4, e1[15:0]);
        chk("b2b_first_flags", {co4, ovf4}, {e1[16], e1[17]});
      end else if (done4) begin
        t2 = cyc;
        chk("b2b_second_s", s4, e2[15:0]);
        chk("b2b_second_flags", {co4, ovf4}, {e2[16], e2[17]});
      end
      if (t1 != 0 && cyc == t1 + 1) drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_latency", t1, 5);
    chk("b2b_spacing", t2 - t1, 5);

    // reset asserted in the 2nd RUN cycle aborts the operation
    @(negedge clk);
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {busy4, done4, co4, ovf4, s4}, 20'h0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(1'b0, 16'h4321, 16'h1111, 1'b1, 0, "after_abort");

    // single-nibble instance
    run_op(1'b1, 16'hA, 16'h5, 1'b0, 0, "w1_add_a_5");
    run_op(1'b1, 16'hF, 16'h1, 1'b0, 0, "w1_add_f_1");
    run_op(1'b1, 16'h8, 16'h1, 1'b1, 0, "w1_sub_8_1");
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1, 0, "rand1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
